// File: rtl/conv_ctrl_gen.sv
// conv_ctrl_gen: parametrised 2-D convolution address/strobe sequencer.
// Walks kernel taps (kc, kr) inside output pixels (oc, orow). It generates
// feature/weight read addresses, the accumulator-clear strobe and the output
// write address/strobe. Each group is delayed to line up with the MAC pipeline.
// Optional feature: define CONV_CTRL_ABORT_EN to add the `abort` input.
module conv_ctrl_gen #(
  parameter int K       = 5,
  parameter int IN_W    = 14,
  parameter int IN_H    = 14,
  parameter int STRIDE  = 1,
  parameter int RD_LAT  = 3,
  parameter int CLR_LAT = 6,
  parameter int WR_LAT  = 13,
  localparam int OUT_W  = (IN_W - K) / STRIDE + 1,
  localparam int OUT_H  = (IN_H - K) / STRIDE + 1,
  localparam int FA_W   = (IN_W * IN_H > 1) ? $clog2(IN_W * IN_H) : 1,
  localparam int WA_W   = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int OA_W   = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef CONV_CTRL_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic [FA_W-1:0] f_raddr,
  output logic [WA_W-1:0] w_raddr,
  output logic            rd_en,
  output logic            mac_clr,
  output logic [OA_W-1:0] o_waddr,
  output logic            o_wr_en,
  output logic            done
);

  localparam int KC_W = (K > 1) ? $clog2(K) : 1;
  localparam int OC_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OR_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  state_t          state_r;
  logic            busy_r;
  logic [KC_W-1:0] kc_r;
  logic [KC_W-1:0] kr_r;
  logic [OC_W-1:0] oc_r;
  logic [OR_W-1:0] orow_r;

  logic            abort_s;
  logic            run_s;
  logic            kc_last_s;
  logic            kr_last_s;
  logic            oc_last_s;
  logic            or_last_s;
  logic            clr_s;
  logic            wr_s;
  logic            dn_s;
  logic [FA_W-1:0] f_s;
  logic [WA_W-1:0] w_s;
  logic [OA_W-1:0] o_s;

  // Delay lines; address stages only load when their strobe is set so outputs hold.
  logic                 rd_vld_r [RD_LAT];
  logic [FA_W+WA_W-1:0] rd_dat_r [RD_LAT];
  logic                 wr_vld_r [WR_LAT];
  logic [OA_W-1:0]      wr_dat_r [WR_LAT];
  logic                 dn_r     [WR_LAT];
  logic                 clr_r    [CLR_LAT];

`ifdef CONV_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Addresses and strobes decoded from the current counter state.
  always_comb begin
    run_s     = (state_r == ST_RUN);
    kc_last_s = (kc_r == KC_W'(K - 1));
    kr_last_s = (kr_r == KC_W'(K - 1));
    oc_last_s = (oc_r == OC_W'(OUT_W - 1));
    or_last_s = (orow_r == OR_W'(OUT_H - 1));
    clr_s     = run_s && (kc_r == KC_W'(0)) && (kr_r == KC_W'(0));
    wr_s      = run_s && kc_last_s && kr_last_s;
    dn_s      = (state_r == ST_DONE);
    f_s       = FA_W'((32'(orow_r) * 32'(STRIDE) + 32'(kr_r)) * 32'(IN_W)
                      + 32'(oc_r) * 32'(STRIDE) + 32'(kc_r));
    w_s       = WA_W'(32'(kr_r) * 32'(K) + 32'(kc_r));
    o_s       = OA_W'(32'(orow_r) * 32'(OUT_W) + 32'(oc_r));
  end

  // Sequencer FSM with tap/pixel counters; counters only move in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      kc_r    <= '0;
      kr_r    <= '0;
      oc_r    <= '0;
      orow_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            kc_r    <= '0;
            kr_r    <= '0;
            oc_r    <= '0;
            orow_r  <= '0;
          end else if (kc_last_s && kr_last_s && oc_last_s && or_last_s) begin
            state_r <= ST_DONE;
            kc_r    <= '0;
            kr_r    <= '0;
            oc_r    <= '0;
            orow_r  <= '0;
          end else if (!kc_last_s) begin
            kc_r <= kc_r + KC_W'(1);
          end else begin
            kc_r <= '0;
            if (!kr_last_s) begin
              kr_r <= kr_r + KC_W'(1);
            end else begin
              kr_r <= '0;
              if (!oc_last_s) begin
                oc_r <= oc_r + OC_W'(1);
              end else begin
                oc_r   <= '0;
                orow_r <= orow_r + OR_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          kc_r    <= '0;
          kr_r    <= '0;
          oc_r    <= '0;
          orow_r  <= '0;
        end
      endcase
    end
  end

  // Read-address delay line (RD_LAT stages).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_r[i] <= 1'b0;
        rd_dat_r[i] <= '0;
      end
    end else begin
      rd_vld_r[0] <= run_s;
      if (run_s) rd_dat_r[0] <= {f_s, w_s};
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_r[i] <= rd_vld_r[i-1];
        if (rd_vld_r[i-1]) rd_dat_r[i] <= rd_dat_r[i-1];
      end
    end
  end

  // Output-write and completion delay line (WR_LAT stages).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WR_LAT; i++) begin
        wr_vld_r[i] <= 1'b0;
        wr_dat_r[i] <= '0;
        dn_r[i]     <= 1'b0;
      end
    end else begin
      wr_vld_r[0] <= wr_s;
      dn_r[0]     <= dn_s;
      if (wr_s) wr_dat_r[0] <= o_s;
      for (int i = 1; i < WR_LAT; i++) begin
        wr_vld_r[i] <= wr_vld_r[i-1];
        dn_r[i]     <= dn_r[i-1];
        if (wr_vld_r[i-1]) wr_dat_r[i] <= wr_dat_r[i-1];
      end
    end
  end

  // Accumulator-clear delay line (CLR_LAT stages).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLR_LAT; i++) clr_r[i] <= 1'b0;
    end else begin
      clr_r[0] <= clr_s;
      for (int i = 1; i < CLR_LAT; i++) clr_r[i] <= clr_r[i-1];
    end
  end

  assign busy               = busy_r;
  assign rd_en              = rd_vld_r[RD_LAT-1];
  assign {f_raddr, w_raddr} = rd_dat_r[RD_LAT-1];
  assign mac_clr            = clr_r[CLR_LAT-1];
  assign o_wr_en            = wr_vld_r[WR_LAT-1];
  assign o_waddr            = wr_dat_r[WR_LAT-1];
  assign done               = dn_r[WR_LAT-1];

endmodule

// File: tb/tb_conv_ctrl_gen.sv
// Directed bench for conv_ctrl_gen: default 5x5/14x14 instance plus a
// K=3, 7x7, stride-2 instance sharing clock, reset and start.
module tb_conv_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
`ifdef CONV_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       busy, rd_en, mac_clr, o_wr_en, done;
  logic [7:0] f_raddr;
  logic [4:0] w_raddr;
  logic [6:0] o_waddr;

  logic       busy2, rd_en2, mac_clr2, o_wr_en2, done2;
  logic [5:0] f_raddr2;
  logic [3:0] w_raddr2;
  logic [3:0] o_waddr2;

  int n_chk  = 0;
  int n_pass = 0;

  // Per-run capture
  int f_q[$], w_q[$], wr_q[$], wr_r[$], done_r[$], clr_r[$], f2_q[$];
  int busy_cnt, busy_rise, rd_first, wr2_cnt, done2_cnt;
  bit busy_prev, rst_zero;

  always #5 clk = ~clk;

  conv_ctrl_gen dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef CONV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .f_raddr(f_raddr), .w_raddr(w_raddr), .rd_en(rd_en),
    .mac_clr(mac_clr), .o_waddr(o_waddr), .o_wr_en(o_wr_en), .done(done)
  );

  conv_ctrl_gen #(.K(3), .IN_W(7), .IN_H(7), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
`ifdef CONV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy2), .f_raddr(f_raddr2), .w_raddr(w_raddr2), .rd_en(rd_en2),
    .mac_clr(mac_clr2), .o_waddr(o_waddr2), .o_wr_en(o_wr_en2), .done(done2)
  );

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Runs len+1 negedges. Sample index s=0 is the first RUN cycle. Inputs are
  // driven at negedge s for the following posedge; a negative index disables it.
  task automatic run_cap(input int len, input int hold, input int rst_at,
                         input int pulse_a, input int pulse_b, input int abort_at);
    f_q.delete(); w_q.delete(); wr_q.delete(); wr_r.delete();
    done_r.delete(); clr_r.delete(); f2_q.delete();
    busy_cnt = 0; busy_rise = 0; rd_first = -1; wr2_cnt = 0; done2_cnt = 0;
    busy_prev = 1'b0; rst_zero = 1'b0;
    for (int i = 0; i <= len; i++) begin
      int s;
      s = i - 1;
      @(negedge clk);
      if (i > 0) begin
        if (busy) busy_cnt++;
        if (busy && !busy_prev) busy_rise++;
        busy_prev = busy;
        if (rd_en) begin
          if (f_q.size() == 0) rd_first = s;
          f_q.push_back(int'(f_raddr));
          w_q.push_back(int'(w_raddr));
        end
        if (mac_clr) clr_r.push_back(s);
        if (o_wr_en) begin
          wr_q.push_back(int'(o_waddr));
          wr_r.push_back(s);
        end
        if (done) done_r.push_back(s);
        if (rd_en2) f2_q.push_back(int'(f_raddr2));
        if (o_wr_en2) wr2_cnt++;
        if (done2) done2_cnt++;
        if (s == rst_at + 1 && rst_at >= 0)
          rst_zero = !busy && !rd_en && !mac_clr && !o_wr_en && !done &&
                     f_raddr == 8'd0 && w_raddr == 5'd0 && o_waddr == 7'd0;
      end
      start = (i < hold) || (s == pulse_a) || (s == pulse_b);
      rst   = (rst_at >= 0) && (s == rst_at);
`ifdef CONV_CTRL_ABORT_EN
      abort = (abort_at >= 0) && (s == abort_at);
`endif
    end
    start = 1'b0;
    rst   = 1'b0;
`ifdef CONV_CTRL_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    int exp_p1[9];
    exp_p1 = '{2, 3, 4, 9, 10, 11, 16, 17, 18};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_rd_en", int'(rd_en), 0);
    check_eq("rst_f_raddr", int'(f_raddr), 0);
    check_eq("rst_w_raddr", int'(w_raddr), 0);
    check_eq("rst_mac_clr", int'(mac_clr), 0);
    check_eq("rst_o_wr_en", int'(o_wr_en), 0);
    check_eq("rst_o_waddr", int'(o_waddr), 0);
    check_eq("rst_done", int'(done), 0);

    // Default single run
    run_cap(2600, 1, -1, -1, -1, -1);
    check_eq("run_busy_cycles", busy_cnt, 2501);
    check_eq("run_busy_rise", busy_rise, 1);
    check_eq("rd_first_cycle", rd_first, 3);
    check_eq("rd_count", f_q.size(), 2500);
    if (f_q.size() == 2500) begin
      check_eq("f_0", f_q[0], 0);
      check_eq("f_1", f_q[1], 1);
      check_eq("f_4", f_q[4], 4);
      check_eq("f_5", f_q[5], 14);
      check_eq("f_6", f_q[6], 15);
      check_eq("f_pix1", f_q[25], 1);
      check_eq("f_last", f_q[2499], 195);
      for (int k = 0; k < 25; k++) check_eq("w_seq", w_q[k], k);
      check_eq("w_pix1", w_q[25], 0);
    end
    check_eq("wr_count", wr_q.size(), 100);
    if (wr_q.size() == 100) begin
      for (int p = 0; p < 100; p++) begin
        check_eq("wr_addr", wr_q[p], p);
        check_eq("wr_cycle", wr_r[p], 25 * p + 37);
      end
    end
    check_eq("clr_count", clr_r.size(), 100);
    if (clr_r.size() == 100)
      for (int p = 0; p < 100; p++) check_eq("clr_cycle", clr_r[p], 25 * p + 6);
    check_eq("done_count", done_r.size(), 1);
    if (done_r.size() == 1) check_eq("done_cycle", done_r[0], 2513);
    check_eq("f_hold", int'(f_raddr), 195);
    check_eq("o_hold", int'(o_waddr), 99);
    check_eq("busy_end", int'(busy), 0);
    // Strided instance
    check_eq("s2_rd_count", f2_q.size(), 81);
    if (f2_q.size() == 81) begin
      for (int k = 0; k < 9; k++) check_eq("s2_pix1_f", f2_q[9 + k], exp_p1[k]);
      check_eq("s2_last_base", f2_q[72], 32);
    end
    check_eq("s2_wr_count", wr2_cnt, 9);
    check_eq("s2_done_count", done2_cnt, 1);

    // Reset mid-run
    run_cap(1200, 1, 999, -1, -1, -1);
    check_eq("mrst_zero", int'(rst_zero), 1);
    check_eq("mrst_wr_count", wr_q.size(), 39);
    check_eq("mrst_done_count", done_r.size(), 0);
    check_eq("mrst_busy_end", int'(busy), 0);

    // Clean run after reset; start pulses in RUN and DONE are ignored
    run_cap(2600, 1, -1, 500, 2500, -1);
    check_eq("clean_busy_cycles", busy_cnt, 2501);
    check_eq("clean_busy_rise", busy_rise, 1);
    check_eq("clean_wr_count", wr_q.size(), 100);
    if (wr_q.size() == 100) check_eq("clean_wr_last", wr_q[99], 99);
    check_eq("clean_done_count", done_r.size(), 1);
    if (done_r.size() == 1) check_eq("clean_done_cycle", done_r[0], 2513);

    // Start held high for 3000 cycles: back-to-back runs
    run_cap(5200, 3000, -1, -1, -1, -1);
    check_eq("hold_busy_rise", busy_rise, 2);
    check_eq("hold_busy_cycles", busy_cnt, 5002);
    check_eq("hold_wr_count", wr_q.size(), 200);
    if (wr_q.size() == 200) begin
      check_eq("hold_wr2_first", wr_q[100], 0);
      check_eq("hold_wr2_first_cycle", wr_r[100], 2502 + 37);
    end
    check_eq("hold_done_count", done_r.size(), 2);
    if (done_r.size() == 2) check_eq("hold_done2_cycle", done_r[1], 5015);

`ifdef CONV_CTRL_ABORT_EN
    // Abort at RUN cycle 60
    run_cap(300, 1, -1, -1, -1, 60);
    check_eq("abort_busy_cycles", busy_cnt, 61);
    check_eq("abort_wr_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check_eq("abort_wr0", wr_q[0], 0);
      check_eq("abort_wr1", wr_q[1], 1);
    end
    check_eq("abort_done_count", done_r.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
